// File: rtl/mbe_mul_arbiter.sv
// Round-robin sequencer sharing one external modified-Booth multiplier among N_REQ requesters.
// It accepts operands, waits the multiplier latency, then returns the product tagged with the requester id.
module mbe_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic [2*WIDTH-1:0]         mul_p,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2*WIDTH-1:0]         rsp_data,
  output logic [$clog2(N_REQ)-1:0]   rsp_id
);
  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDW-1:0]       r_rr_ptr;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_op_a;
  logic [WIDTH-1:0]     r_op_b;
  logic                 r_rsp_valid;
  logic [2*WIDTH-1:0]   r_rsp_data;
  logic [IDW-1:0]       r_rsp_id;

  logic                 w_found;
  logic [IDW-1:0]       w_gnt;
  logic [IDW:0]         w_idx;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_sel_a;
  logic [WIDTH-1:0]     w_sel_b;
  logic [IDW-1:0]       w_ptr_nxt;

  // Round-robin search from r_rr_ptr; the index wraps explicitly so non-power-of-two N_REQ works.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(N_REQ)) begin
        w_idx = w_idx - (IDW+1)'(N_REQ);
      end else begin
        w_idx = w_idx;
      end
      if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_idx[IDW-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // Operand mux for the granted requester and the advanced pointer.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt == IDW'(k)) begin
        w_sel_a = req_a[k*WIDTH +: WIDTH];
        w_sel_b = req_b[k*WIDTH +: WIDTH];
      end else begin
        w_sel_a = w_sel_a;
      end
    end
    if (w_gnt == IDW'(N_REQ - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_gnt + IDW'(1);
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found;

  // Grant is combinational and masked while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (w_accept && rst) begin
      req_ready[w_gnt] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_found) w_state_nxt = S_BUSY;
        else         w_state_nxt = S_IDLE;
      end
      S_BUSY: begin
        if (r_cnt == CW'(1)) w_state_nxt = S_SEND;
        else                 w_state_nxt = S_BUSY;
      end
      S_SEND: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_SEND;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Datapath: operand capture, latency count, response hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op_a   <= w_sel_a;
            r_op_b   <= w_sel_b;
            r_rsp_id <= w_gnt;
            r_rr_ptr <= w_ptr_nxt;
            r_cnt    <= CW'(LAT);
          end else begin
            r_cnt    <= r_cnt;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_rsp_data  <= mul_p;
            r_rsp_valid <= 1'b1;
          end else begin
            r_rsp_valid <= 1'b0;
          end
        end
        S_SEND: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
          else           r_rsp_valid <= 1'b1;
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign mul_a     = r_op_a;
  assign mul_b     = r_op_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
endmodule

// File: tb/tb_mbe_mul_arbiter.sv
// Bench for mbe_mul_arbiter: two instances (LAT=1 and LAT=3) with a signed multiplier model,
// directed vector table, hand sequences for stall/reset corners, and randomized transactions.
module tb_mbe_mul_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]     req_valid [2];
  logic [N-1:0]     req_ready [2];
  logic [N*W-1:0]   req_a     [2];
  logic [N*W-1:0]   req_b     [2];
  logic [W-1:0]     mul_a     [2];
  logic [W-1:0]     mul_b     [2];
  logic [2*W-1:0]   rsp_data  [2];
  logic             rsp_valid [2];
  logic             rsp_ready [2];
  logic [1:0]       rsp_id    [2];
  logic [2*W-1:0]   mp0, mp1, p1_q, p2_q;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ptr = 0;

  mbe_mul_arbiter #(.N_REQ(4), .WIDTH(32), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_p(mp0),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_id(rsp_id[0]));

  mbe_mul_arbiter #(.N_REQ(4), .WIDTH(32), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_p(mp1),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_id(rsp_id[1]));

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    longint x;
    longint y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  // Multiplier models: combinational for LAT=1, two register stages for LAT=3.
  assign mp0 = smul(mul_a[0], mul_b[0]);
  always @(posedge clk) begin
    p1_q <= smul(mul_a[1], mul_b[1]);
    p2_q <= p1_q;
    cyc  <= cyc + 1;
  end
  assign mp1 = p2_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [3:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset(input int d);
    rst = 1'b0;
    req_valid[0] = '0; req_valid[1] = '0;
    req_valid[d] = 4'hF;
    rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_req_ready", 64'(req_ready[d]), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid[d]), 64'h0);
    chk("rst_rsp_data", rsp_data[d], 64'h0);
    chk("rst_rsp_id", 64'(rsp_id[d]), 64'h0);
    chk("rst_mul_a", 64'(mul_a[d]), 64'h0);
    chk("rst_mul_b", 64'(mul_b[d]), 64'h0);
    req_valid[d] = '0;
    rst = 1'b1;
    ptr = 0;
    @(negedge clk);
  endtask

  // One full transaction from IDLE: grant, busy window, response, optional stall, return to IDLE.
  task automatic run_txn(input int d, input logic [3:0] v, input logic [127:0] a, input logic [127:0] b,
                         input int stall, output int g_obs, output logic [63:0] data_obs, output int acc_cyc);
    int eg;
    int lat;
    int waited;
    logic [3:0] eoh;
    logic [31:0] ea, eb;
    logic [63:0] ed;
    lat = (d == 0) ? 1 : 3;
    g_obs = -1;
    data_obs = '0;
    req_valid[d] = v; req_a[d] = a; req_b[d] = b;
    rsp_ready[d] = (stall == 0);
    #1;
    waited = 0;
    while (req_ready[d] == 4'b0000 && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    acc_cyc = cyc;
    chk("grant_wait", 64'(waited), 64'h0);
    if (req_ready[d] == 4'b0000) begin
      chk("grant_timeout", 64'h0, 64'h1);
      return;
    end
    eg = model_grant(v);
    eoh = 4'b0001 << eg;
    chk("grant_onehot", 64'(req_ready[d]), 64'(eoh));
    for (int i = 0; i < N; i++) if (req_ready[d][i]) g_obs = i;
    ptr = (eg + 1) % N;
    ea = a[eg*32 +: 32];
    eb = b[eg*32 +: 32];
    ed = smul(ea, eb);
    @(negedge clk);
    for (int k = 1; k <= lat; k++) begin
      chk("busy_rsp_valid", 64'(rsp_valid[d]), 64'h0);
      chk("busy_req_ready", 64'(req_ready[d]), 64'h0);
      chk("busy_mul_a", 64'(mul_a[d]), 64'(ea));
      chk("busy_mul_b", 64'(mul_b[d]), 64'(eb));
      @(negedge clk);
    end
    chk("rsp_valid", 64'(rsp_valid[d]), 64'h1);
    chk("rsp_data", rsp_data[d], ed);
    chk("rsp_id", 64'(rsp_id[d]), 64'(eg));
    data_obs = rsp_data[d];
    if (stall > 0) begin
      for (int s = 1; s <= stall; s++) begin
        @(negedge clk);
        chk("stall_valid", 64'(rsp_valid[d]), 64'h1);
        chk("stall_data", rsp_data[d], ed);
        chk("stall_id", 64'(rsp_id[d]), 64'(eg));
        chk("stall_req_ready", 64'(req_ready[d]), 64'h0);
      end
      rsp_ready[d] = 1'b1;
    end
    @(negedge clk);
    chk("rsp_drop", 64'(rsp_valid[d]), 64'h0);
  endtask

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;
  vec_t tbl[5];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, ac, prev_ac, lat;
    logic [63:0] dat;
    logic [127:0] ra, rb;
    logic [3:0] v;
    int exp_order[5];

    tbl[0] = '{req: 1, a: 32'd7,         b: 32'hFFFF_FFFD, p: 64'hFFFF_FFFF_FFFF_FFEB};
    tbl[1] = '{req: 0, a: 32'h8000_0000, b: 32'h8000_0000, p: 64'h4000_0000_0000_0000};
    tbl[2] = '{req: 3, a: 32'h7FFF_FFFF, b: 32'h8000_0000, p: 64'hC000_0000_8000_0000};
    tbl[3] = '{req: 2, a: 32'h0000_0000, b: 32'h1234_5678, p: 64'h0000_0000_0000_0000};
    tbl[4] = '{req: 1, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, p: 64'h0000_0000_0000_0001};
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0; req_a[d] = '0; req_b[d] = '0; rsp_ready[d] = 1'b1;
    end
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      do_reset(d);

      // Directed operand table (single requester each).
      for (int t = 0; t < 5; t++) begin
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        ra[tbl[t].req*32 +: 32] = tbl[t].a;
        rb[tbl[t].req*32 +: 32] = tbl[t].b;
        v = 4'b0001 << tbl[t].req;
        run_txn(d, v, ra, rb, 0, g, dat, ac);
        chk("tbl_id", 64'(g), 64'(tbl[t].req));
        chk("tbl_data", dat, tbl[t].p);
        req_valid[d] = '0;
      end

      // All four requesting: strict rotation and LAT+2 spacing.
      do_reset(d);
      prev_ac = 0;
      for (int t = 0; t < 5; t++) begin
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        run_txn(d, 4'hF, ra, rb, 0, g, dat, ac);
        chk("rr_order", 64'(g), 64'(exp_order[t]));
        if (t > 0) chk("rr_spacing", 64'(ac - prev_ac), 64'(lat + 2));
        prev_ac = ac;
      end
      req_valid[d] = '0;

      // After a grant to 2, only 0 and 3 request: 3 then 0.
      do_reset(d);
      run_txn(d, 4'b0100, ra, rb, 0, g, dat, ac);
      chk("seq3_g2", 64'(g), 64'd2);
      run_txn(d, 4'b1001, ra, rb, 0, g, dat, ac);
      chk("seq3_g3", 64'(g), 64'd3);
      run_txn(d, 4'b1001, ra, rb, 0, g, dat, ac);
      chk("seq3_g0", 64'(g), 64'd0);

      // Response back-pressure for 5 cycles; grant resumes right after release.
      run_txn(d, 4'b0110, ra, rb, 5, g, dat, ac);
      #1;
      chk("idle_after_release", 64'(req_ready[d] != 4'b0000), 64'h1);
      req_valid[d] = '0;

      // Reset while BUSY drops the op and resets the pointer.
      do_reset(d);
      req_valid[d] = 4'b0010; rsp_ready[d] = 1'b1;
      #1;
      chk("rstbusy_grant", 64'(req_ready[d]), 64'h2);
      @(negedge clk);
      req_valid[d] = 4'b0101;
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("rstcyc_req_ready", 64'(req_ready[d]), 64'h0);
      chk("rstcyc_rsp_valid", 64'(rsp_valid[d]), 64'h0);
      rst = 1'b1;
      req_valid[d] = '0;
      ptr = 0;
      for (int k = 0; k < lat + 2; k++) begin
        @(negedge clk);
        chk("rstbusy_no_rsp", 64'(rsp_valid[d]), 64'h0);
      end
      run_txn(d, 4'b0101, ra, rb, 0, g, dat, ac);
      chk("rstbusy_first", 64'(g), 64'd0);

      // Randomized traffic against the round-robin/product model.
      for (int t = 0; t < 30; t++) begin
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        v = 4'($urandom_range(1, 15));
        run_txn(d, v, ra, rb, int'($urandom_range(0, 3)), g, dat, ac);
      end
      req_valid[d] = '0;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
